mf_feeder: RTL

MF_FEEDER -- requirements
Module: mf_feeder

---
 rtl/mf_feeder_if.sv | 29 ++
 rtl/mf_feeder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mf_feeder_if.sv
// Handshake bundle between the producer / transaction block and the MF feeder.
// The master side drives the producer word and transaction-block status; the slave side is the feeder.
interface mf_feeder_if #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              almost_full_MF;
    logic              active_in;
    logic              error_in;
    logic              push_MF;
    logic [DATA_W-1:0] data_out;
    logic [FILL_W-1:0] fill;
    logic [1:0]        state_out;

    modport master (
        output in_valid, in_data, almost_full_MF, active_in, error_in,
        input  in_ready, push_MF, data_out, fill, state_out
    );

    modport slave (
        input  in_valid, in_data, almost_full_MF, active_in, error_in,
        output in_ready, push_MF, data_out, fill, state_out
    );
endinterface

// File: rtl/mf_feeder.sv
// Skid FIFO feeding the main FIFO under a STOP/RUN/HOLD/ERR controller; registered push, 1-cycle min latency.
// Backpressure: almost_full_MF stalls sends and in_ready drops when full, stopped or in error. Optional MF_FEEDER_STATS_EN adds sent_cnt.
module mf_feeder #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    mf_feeder_if.slave  bus
`ifdef MF_FEEDER_STATS_EN
    ,
    output logic [7:0]  sent_cnt
`endif
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic in_ready;
    logic accept;
    logic send;

    assign in_ready = (fill_q < FILL_W'(DEPTH)) && (state_q != ERR) && (state_q != STOP);
    assign accept   = bus.in_valid && in_ready;
    // An edge that enters ERR flushes the FIFO, so nothing may leave on it either.
    assign send     = (state_q == RUN) && (fill_q != '0) && !bus.almost_full_MF && !bus.error_in;

    always_comb begin
        state_d = state_q;
        if (bus.error_in) begin
            state_d = ERR;
        end else begin
            unique case (state_q)
                STOP: if (bus.active_in) state_d = RUN;
                RUN: begin
                    if (bus.almost_full_MF)  state_d = HOLD;
                    else if (!bus.active_in) state_d = STOP;
                end
                HOLD: begin
                    if (!bus.almost_full_MF && bus.active_in) state_d = RUN;
                    else if (!bus.active_in)                  state_d = STOP;
                end
                ERR:     state_d = STOP;
                default: state_d = STOP;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        push_d   = 1'b0;
        data_d   = data_q;
        if (bus.error_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (send) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                push_d   = 1'b1;
                data_d   = mem_q[rd_ptr_q];
            end
            fill_d = fill_q + FILL_W'(accept) - FILL_W'(send);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STOP;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            push_q   <= push_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: fill and the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= bus.in_data;
    end

`ifdef MF_FEEDER_STATS_EN
    logic [7:0] sent_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       sent_cnt_q <= '0;
        else if (push_q) sent_cnt_q <= sent_cnt_q + 8'd1;
    end

    assign sent_cnt = sent_cnt_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.push_MF   = push_q;
    assign bus.data_out  = data_q;
    assign bus.fill      = fill_q;
    assign bus.state_out = state_q;
endmodule
